// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its side-road request front end.
package traffic_pkg;

   // Side-request FSM state encoding.
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPending = 2'd1,
      StServing = 2'd2,
      StHoldoff = 2'd3
   } side_state_e;

   // Default timing constants shared with traffic_light.
   localparam int unsigned DefDebounceCycles = 3;
   localparam int unsigned DefHoldoffCycles  = 10;
   localparam int unsigned DefCntW           = 8;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, level debouncer and one-cycle press pulse on the debounced rising edge.
module btn_debounce
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic press
);

   localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);

   logic            sync1_q, sync_q;
   logic            db_q, db_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;

   // Count consecutive samples that disagree with the held level; flip once enough agree.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync_q != db_q) begin
         cnt_d = cnt_q + CntW'(1);
         if (cnt_d == CntW'(DEBOUNCE_CYCLES)) begin
            db_d  = ~db_q;
            cnt_d = '0;
         end
      end
      press_d = db_d & ~db_q;
   end

   // Synchroniser, debounce state and registered press pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync_q  <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= din;
         sync_q  <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign level = db_q;
   assign press = press_q;

endmodule

// File: rtl/side_req_ctrl.sv
// Side-road demand conditioner: holds req until the side road is served, then enforces a hold-off.
module side_req_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned HOLDOFF_CYCLES  = DefHoldoffCycles,
   parameter int unsigned CNT_W           = DefCntW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_raw,
   input  logic             green_side,
   output logic             req,
   output logic             wait_lamp,
   output logic [CNT_W-1:0] served_cnt
);

   localparam int unsigned HoldW = cnt_width(HOLDOFF_CYCLES);

   logic             press;
   logic             unused_level;

   side_state_e      state_q, state_d;
   logic             latched_q, latched_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] served_q, served_d;
   logic             req_q, req_d;
   logic             wait_q, wait_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_raw),
      .level(unused_level),
      .press(press)
   );

   // Next-state logic; green_side always wins over a coincident press or hold-off expiry.
   always_comb begin
      state_d   = state_q;
      latched_d = latched_q;
      hold_d    = hold_q;
      served_d  = served_q;
      unique case (state_q)
         StIdle: begin
            if (green_side) begin
               state_d = StServing;
            end else if (press) begin
               state_d = StPending;
            end
         end
         StPending: begin
            if (green_side) begin
               state_d = StServing;
               if (served_q != '1) begin
                  served_d = served_q + CNT_W'(1);
               end
            end
         end
         StServing: begin
            if (!green_side) begin
               if (HOLDOFF_CYCLES == 0) begin
                  state_d = StIdle;
               end else begin
                  state_d = StHoldoff;
                  hold_d  = HoldW'(HOLDOFF_CYCLES - 1);
               end
            end
         end
         StHoldoff: begin
            if (green_side) begin
               state_d   = StServing;
               latched_d = 1'b0;
            end else if (hold_q == '0) begin
               // A press landing on the expiry cycle still counts.
               state_d   = (latched_q || press) ? StPending : StIdle;
               latched_d = 1'b0;
            end else begin
               hold_d = hold_q - HoldW'(1);
               if (press) begin
                  latched_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      req_d  = (state_d == StPending);
      wait_d = req_d | latched_d;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         latched_q <= 1'b0;
         hold_q    <= '0;
         served_q  <= '0;
         req_q     <= 1'b0;
         wait_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         latched_q <= latched_d;
         hold_q    <= hold_d;
         served_q  <= served_d;
         req_q     <= req_d;
         wait_q    <= wait_d;
      end
   end

   assign req        = req_q;
   assign wait_lamp  = wait_q;
   assign served_cnt = served_q;

endmodule

// File: tb/tb_side_req_ctrl.sv
// Directed bench for side_req_ctrl: default instance plus a CNT_W=2 instance for saturation.
module tb_side_req_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, btn_raw, green_side;
   logic       req, wait_lamp;
   logic [7:0] served_cnt;

   logic       rst2 = 1'b0, btn2 = 1'b0, gs2 = 1'b0;
   logic       req2, wl2;
   logic [1:0] served2;

   int errors = 0;
   int checks = 0;

   side_req_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .green_side(green_side),
      .req       (req),
      .wait_lamp (wait_lamp),
      .served_cnt(served_cnt)
   );

   side_req_ctrl #(
      .CNT_W(2)
   ) dut2 (
      .clk       (clk),
      .rst       (rst2),
      .btn_raw   (btn2),
      .green_side(gs2),
      .req       (req2),
      .wait_lamp (wl2),
      .served_cnt(served2)
   );

   function automatic logic in_rng(input int c, input int lo, input int hi);
      return (c >= lo) && (c < hi);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; btn_raw = 1'b0; green_side = 1'b0;
      tick(); tick();
      rst = 1'b1;
   endtask

   // Reset with the button already high, then measure first-press latency.
   task automatic test_reset();
      rst = 1'b0; btn_raw = 1'b1; green_side = 1'b0;
      tick(); tick();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req); end
      checks++; if (wait_lamp !== 1'b0) begin errors++; $display("FAIL reset_wait got %b exp 0", wait_lamp); end
      checks++; if (served_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", served_cnt); end
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if (req !== (c >= 5)) begin
            errors++; $display("FAIL reset_latency_req c=%0d got %b exp %b", c, req, (c >= 5));
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int c = 0; c < 22; c++) begin
         btn_raw = in_rng(c, 0, 2);
         tick();
         checks++;
         if (req !== 1'b0 || wait_lamp !== 1'b0) begin
            errors++; $display("FAIL glitch c=%0d got req=%b wait=%b exp 0/0", c, req, wait_lamp);
         end
      end
   endtask

   task automatic test_normal();
      logic exp;
      do_reset();
      for (int c = 0; c < 86; c++) begin
         btn_raw = in_rng(c, 0, 6); green_side = in_rng(c, 40, 70);
         tick();
         exp = in_rng(c, 5, 40);
         checks++;
         if (req !== exp || wait_lamp !== exp) begin
            errors++; $display("FAIL normal c=%0d got req=%b wait=%b exp %b", c, req, wait_lamp, exp);
         end
      end
      checks++; if (served_cnt !== 8'd1) begin errors++; $display("FAIL normal_cnt got %0d exp 1", served_cnt); end
   endtask

   task automatic test_holdoff_latch();
      logic er, ew;
      do_reset();
      for (int c = 0; c < 35; c++) begin
         btn_raw = in_rng(c, 0, 6) | in_rng(c, 17, 23); green_side = in_rng(c, 10, 20);
         tick();
         er = in_rng(c, 5, 10) | (c >= 30);
         ew = in_rng(c, 5, 10) | (c >= 22);
         checks++;
         if (req !== er || wait_lamp !== ew) begin
            errors++; $display("FAIL holdoff_latch c=%0d got req=%b wait=%b exp %b/%b", c, req, wait_lamp, er, ew);
         end
      end
   endtask

   task automatic test_holdoff_edge();
      logic exp;
      do_reset();
      for (int c = 0; c < 34; c++) begin
         btn_raw = in_rng(c, 0, 6) | in_rng(c, 25, 31); green_side = in_rng(c, 10, 20);
         tick();
         exp = in_rng(c, 5, 10) | (c >= 30);
         checks++;
         if (req !== exp || wait_lamp !== exp) begin
            errors++; $display("FAIL holdoff_edge c=%0d got req=%b wait=%b exp %b", c, req, wait_lamp, exp);
         end
      end
   endtask

   task automatic test_held();
      int   rises;
      logic prev;
      rises = 0; prev = 1'b0;
      do_reset();
      for (int c = 0; c < 112; c++) begin
         btn_raw = in_rng(c, 0, 100); green_side = in_rng(c, 40, 60);
         tick();
         if (req && !prev) rises++;
         prev = req;
         checks++;
         if (req !== in_rng(c, 5, 40)) begin
            errors++; $display("FAIL held_req c=%0d got %b exp %b", c, req, in_rng(c, 5, 40));
         end
      end
      checks++; if (rises !== 1) begin errors++; $display("FAIL held_rises got %0d exp 1", rises); end
      checks++; if (served_cnt !== 8'd1) begin errors++; $display("FAIL held_cnt got %0d exp 1", served_cnt); end
   endtask

   // Press and grant on the same edge while pending: the grant wins and the press is lost.
   task automatic test_simultaneous();
      logic exp;
      do_reset();
      for (int c = 0; c < 42; c++) begin
         btn_raw = in_rng(c, 0, 6) | in_rng(c, 15, 21); green_side = in_rng(c, 20, 25);
         tick();
         exp = in_rng(c, 5, 20);
         checks++;
         if (req !== exp || wait_lamp !== exp) begin
            errors++; $display("FAIL simultaneous c=%0d got req=%b wait=%b exp %b", c, req, wait_lamp, exp);
         end
      end
      checks++; if (served_cnt !== 8'd1) begin errors++; $display("FAIL simultaneous_cnt got %0d exp 1", served_cnt); end
   endtask

   task automatic test_unsolicited();
      do_reset();
      for (int c = 0; c < 25; c++) begin
         green_side = in_rng(c, 3, 8);
         tick();
         checks++;
         if (req !== 1'b0 || wait_lamp !== 1'b0) begin
            errors++; $display("FAIL unsolicited c=%0d got req=%b wait=%b exp 0/0", c, req, wait_lamp);
         end
      end
      checks++; if (served_cnt !== 8'd0) begin errors++; $display("FAIL unsolicited_cnt got %0d exp 0", served_cnt); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp;
      rst2 = 1'b0; btn2 = 1'b0; gs2 = 1'b0;
      tick(); tick();
      rst2 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         for (int c = 0; c < 30; c++) begin
            btn2 = in_rng(c, 0, 6); gs2 = in_rng(c, 10, 14);
            tick();
         end
         exp = (k > 3) ? 2'd3 : 2'(k);
         checks++;
         if (served2 !== exp) begin errors++; $display("FAIL sat_cnt round=%0d got %0d exp %0d", k, served2, exp); end
      end
      for (int c = 0; c < 6; c++) begin
         btn2 = 1'b1;
         tick();
      end
      checks++; if (req2 !== 1'b1) begin errors++; $display("FAIL sat_pending_req got %b exp 1", req2); end
      rst2 = 1'b0;
      tick();
      checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL midreset_req got %b exp 0", req2); end
      checks++; if (wl2 !== 1'b0) begin errors++; $display("FAIL midreset_wait got %b exp 0", wl2); end
      checks++; if (served2 !== 2'd0) begin errors++; $display("FAIL midreset_cnt got %0d exp 0", served2); end
      rst2 = 1'b1; btn2 = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL midreset_retained got %b exp 0", req2); end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_normal();
      test_holdoff_latch();
      test_holdoff_edge();
      test_held();
      test_simultaneous();
      test_unsolicited();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
